// File: rtl/branch_predictor.sv
// Branch resolution and direct-mapped saturating-counter predictor.
// Fetch reads the table combinationally; execute resolves the outcome, trains the table and keeps statistics.
module branch_predictor #(
   parameter int ENTRIES  = 64,
   parameter int CTR_W    = 2,
   parameter int INIT_CTR = 1,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      if_pc,
   output logic             if_pred_taken,
   input  logic             ex_valid,
   input  logic [31:0]      ex_pc,
   input  logic [31:0]      ex_inst,
   input  logic             br_eq,
   input  logic             br_lt,
   input  logic             ex_pred_taken,
   output logic             ex_is_branch,
   output logic             ex_taken,
   output logic             mispredict,
   input  logic             stats_clr,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] mispred_count
);
   localparam int               IDX_W      = $clog2(ENTRIES);
   localparam logic [6:0]       OPC_BRANCH = 7'b1100011;
   localparam logic [2:0]       F3_BEQ     = 3'b000;
   localparam logic [2:0]       F3_BNE     = 3'b001;
   localparam logic [2:0]       F3_BLT     = 3'b100;
   localparam logic [2:0]       F3_BGE     = 3'b101;
   localparam logic [2:0]       F3_BLTU    = 3'b110;
   localparam logic [2:0]       F3_BGEU    = 3'b111;
   localparam logic [CTR_W-1:0] CTR_MAX    = {CTR_W{1'b1}};
   localparam logic [CTR_W-1:0] CTR_MIN    = {CTR_W{1'b0}};
   localparam logic [CTR_W-1:0] CTR_INIT   = CTR_W'(INIT_CTR);

   logic [CTR_W-1:0] ctr_q [ENTRIES];
   logic [CTR_W-1:0] ctr_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;
   logic [IDX_W-1:0] if_idx_s, ex_idx_s;
   logic             f3_ok_s, cond_s;
   logic             unused_s;

   assign if_idx_s      = if_pc[IDX_W+1:2];
   assign ex_idx_s      = ex_pc[IDX_W+1:2];
   assign if_pred_taken = ctr_q[if_idx_s][CTR_W-1];
   assign br_count      = br_cnt_q;
   assign mispred_count = mp_cnt_q;
   assign unused_s      = ^{if_pc[31:IDX_W+2], if_pc[1:0], ex_pc[31:IDX_W+2], ex_pc[1:0],
                            ex_inst[31:15], ex_inst[11:7]};

   // Decode funct3 and pick the comparator condition for the branch type
   always_comb begin
      f3_ok_s = 1'b0;
      cond_s  = 1'b0;
      case (ex_inst[14:12])
         F3_BEQ:  begin f3_ok_s = 1'b1; cond_s = br_eq;  end
         F3_BNE:  begin f3_ok_s = 1'b1; cond_s = !br_eq; end
         F3_BLT:  begin f3_ok_s = 1'b1; cond_s = br_lt;  end
         F3_BGE:  begin f3_ok_s = 1'b1; cond_s = !br_lt; end
         F3_BLTU: begin f3_ok_s = 1'b1; cond_s = br_lt;  end
         F3_BGEU: begin f3_ok_s = 1'b1; cond_s = !br_lt; end
         default: begin f3_ok_s = 1'b0; cond_s = 1'b0;   end
      endcase
   end

   assign ex_is_branch = ex_valid && (ex_inst[6:0] == OPC_BRANCH) && f3_ok_s;
   assign ex_taken     = ex_is_branch && cond_s;
   assign mispredict   = ex_is_branch && (ex_taken != ex_pred_taken);

   // Saturating next value for the entry being trained
   always_comb begin
      ctr_d = ctr_q[ex_idx_s];
      if (ex_taken) begin
         if (ctr_q[ex_idx_s] != CTR_MAX) begin
            ctr_d = ctr_q[ex_idx_s] + CTR_W'(1);
         end else begin
            ctr_d = CTR_MAX;
         end
      end else begin
         if (ctr_q[ex_idx_s] != CTR_MIN) begin
            ctr_d = ctr_q[ex_idx_s] - CTR_W'(1);
         end else begin
            ctr_d = CTR_MIN;
         end
      end
   end

   // Statistics next-state; a clear beats a same-cycle increment
   always_comb begin
      br_cnt_d = br_cnt_q;
      mp_cnt_d = mp_cnt_q;
      if (stats_clr) begin
         br_cnt_d = '0;
         mp_cnt_d = '0;
      end else if (ex_is_branch) begin
         br_cnt_d = br_cnt_q + CNT_W'(1);
         mp_cnt_d = mispredict ? (mp_cnt_q + CNT_W'(1)) : mp_cnt_q;
      end else begin
         br_cnt_d = br_cnt_q;
         mp_cnt_d = mp_cnt_q;
      end
   end

   // Counter table: trained only on resolved branches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_q[i] <= CTR_INIT;
         end
      end else if (ex_is_branch) begin
         ctr_q[ex_idx_s] <= ctr_d;
      end
   end

   // Statistics registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_cnt_q <= '0;
         mp_cnt_q <= '0;
      end else begin
         br_cnt_q <= br_cnt_d;
         mp_cnt_q <= mp_cnt_d;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: driver pushes model expectations, monitor compares at negedge.
module tb_branch_predictor;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] if_pc = 32'h0;
   logic        if_pred_taken;
   logic        ex_valid = 1'b0;
   logic [31:0] ex_pc = 32'h0;
   logic [31:0] ex_inst = 32'h0;
   logic        br_eq = 1'b0;
   logic        br_lt = 1'b0;
   logic        ex_pred_taken = 1'b0;
   logic        ex_is_branch;
   logic        ex_taken;
   logic        mispredict;
   logic        stats_clr = 1'b0;
   logic [31:0] br_count;
   logic [31:0] mispred_count;

   branch_predictor dut (
      .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_inst(ex_inst), .br_eq(br_eq), .br_lt(br_lt),
      .ex_pred_taken(ex_pred_taken), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
      .mispredict(mispredict), .stats_clr(stats_clr), .br_count(br_count),
      .mispred_count(mispred_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        pred;
      logic        isb;
      logic        tk;
      logic        mp;
      logic [31:0] bc;
      logic [31:0] mc;
      int          id;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          passes = 0;
   int          step = 0;
   bit          drv_done = 1'b0;

   // Reference model: plain counters per table slot, statistics as integers
   int unsigned m_ctr[64];
   bit [31:0]   m_bc, m_mc;

   function automatic void model_reset();
      for (int i = 0; i < 64; i++) m_ctr[i] = 1;
      m_bc = 0;
      m_mc = 0;
   endfunction

   function automatic int slot(input logic [31:0] pc);
      return int'((pc / 4) % 64);
   endfunction

   function automatic logic [31:0] mk_inst(input logic [2:0] f3);
      logic [31:0] r;
      r = $urandom;
      r[14:12] = f3;
      r[6:0] = 7'h63;
      return r;
   endfunction

   task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, exp);
   endtask

   task automatic drive(input bit rstn, input logic [31:0] ipc, input bit v, input logic [31:0] pc,
                        input logic [31:0] inst, input bit eq, input bit lt, input bit pt, input bit clr);
      exp_t e;
      bit isb, tk;
      @(posedge clk);
      #2;
      rst_n = rstn; if_pc = ipc; ex_valid = v; ex_pc = pc; ex_inst = inst;
      br_eq = eq; br_lt = lt; ex_pred_taken = pt; stats_clr = clr;
      if (!rstn) model_reset();
      isb = 1'b0; tk = 1'b0;
      if (v && inst[6:0] == 7'h63) begin
         case (inst[14:12])
            3'd0: begin isb = 1'b1; tk = eq;  end
            3'd1: begin isb = 1'b1; tk = !eq; end
            3'd4, 3'd6: begin isb = 1'b1; tk = lt;  end
            3'd5, 3'd7: begin isb = 1'b1; tk = !lt; end
            default: begin isb = 1'b0; tk = 1'b0; end
         endcase
      end
      e.pred = (m_ctr[slot(ipc)] >= 2);
      e.isb = isb; e.tk = tk; e.mp = isb && (tk != pt);
      e.bc = m_bc; e.mc = m_mc; e.id = step;
      exp_q.push_back(e);
      step++;
      if (rstn) begin
         if (isb) begin
            if (tk) m_ctr[slot(pc)] = (m_ctr[slot(pc)] == 3) ? 3 : m_ctr[slot(pc)] + 1;
            else    m_ctr[slot(pc)] = (m_ctr[slot(pc)] == 0) ? 0 : m_ctr[slot(pc)] - 1;
         end
         if (clr) begin
            m_bc = 0; m_mc = 0;
         end else if (isb) begin
            m_bc = m_bc + 1;
            if (e.mp) m_mc = m_mc + 1;
         end
      end
   endtask

   task automatic idle(input logic [31:0] ipc);
      drive(1'b1, ipc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Monitor: compare whatever the DUT presents against the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("if_pred_taken", e.id, {31'b0, if_pred_taken}, {31'b0, e.pred});
            check("ex_is_branch",  e.id, {31'b0, ex_is_branch},  {31'b0, e.isb});
            check("ex_taken",      e.id, {31'b0, ex_taken},      {31'b0, e.tk});
            check("mispredict",    e.id, {31'b0, mispredict},    {31'b0, e.mp});
            check("br_count",      e.id, br_count,      e.bc);
            check("mispred_count", e.id, mispred_count, e.mc);
         end
      end
   end

   // Driver: directed scenarios followed by randomized traffic
   initial begin
      logic [31:0] inst;
      model_reset();
      repeat (2) @(posedge clk);
      for (int a = 0; a < 64; a++) idle(32'(a * 4));
      for (int k = 0; k < 3; k++) drive(1'b1, 32'h40, 1'b1, 32'h40, mk_inst(3'b000), 1'b1, 1'b0, 1'b0, 1'b0);
      idle(32'h40);
      for (int k = 0; k < 2; k++) drive(1'b1, 32'h80, 1'b1, 32'h80, mk_inst(3'b111), 1'b0, 1'b1, 1'b1, 1'b0);
      idle(32'h80);
      drive(1'b1, 32'h84, 1'b1, 32'h84, mk_inst(3'b001), 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) drive(1'b1, 32'h100, 1'b1, 32'h0, mk_inst(3'b000), 1'b1, 1'b0, 1'b1, 1'b0);
      idle(32'h100);
      drive(1'b1, 32'h44, 1'b0, 32'h44, mk_inst(3'b000), 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'h44, 1'b1, 32'h44, mk_inst(3'b010), 1'b1, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 32'h44, 1'b1, 32'h44, mk_inst(3'b011), 1'b0, 1'b0, 1'b1, 1'b0);
      idle(32'h44);
      drive(1'b1, 32'h48, 1'b1, 32'h48, mk_inst(3'b100), 1'b0, 1'b1, 1'b0, 1'b1);
      idle(32'h48);
      drive(1'b1, 32'h40, 1'b1, 32'h40, mk_inst(3'b000), 1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 32'h40, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(32'h40);
      for (int n = 0; n < 500; n++) begin
         inst = mk_inst(3'($urandom_range(0, 7)));
         if ($urandom_range(0, 9) == 0) inst[6:0] = 7'($urandom);
         drive(1'b1, $urandom_range(0, 32'h3FF), ($urandom_range(0, 6) != 0),
               $urandom_range(0, 32'h3FF), inst, 1'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 40) == 0));
      end
      drv_done = 1'b1;
   end

   // Termination: drain the scoreboard within a bounded number of cycles
   initial begin
      int guard;
      guard = 0;
      while (!drv_done && guard < 5000) begin
         @(posedge clk);
         guard++;
      end
      repeat (20) begin
         if (exp_q.size() != 0) @(negedge clk);
      end
      checks++;
      if (drv_done && exp_q.size() == 0) passes++;
      else $display("FAIL drain: done=%0d pending=%0d expected done=1 pending=0", drv_done, exp_q.size());
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch resolution and prediction unit for the RISC-V core.
- Holds a direct-mapped table of saturating counters indexed by PC. Fetch reads it combinationally for a taken/not-taken prediction.
- In execute, the unit resolves the actual outcome from the instruction and the comparator flags (BrEq/BrLT), flags a mispredict, trains the table, and keeps branch/mispredict statistics for the CSR block.

Parameters:
- ENTRIES, 64, number of table entries; power of two, >= 2. IDX_W = log2(ENTRIES).
- CTR_W, 2, counter width in bits; >= 1. Prediction = counter MSB.
- INIT_CTR, 1, reset value of every counter; must be < 2^CTR_W. Default is weakly not-taken.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_pc  in  32  fetch-stage PC.
- if_pred_taken  out  1  combinational prediction for if_pc.
- ex_valid  in  1  execute-stage instruction is valid (not bubble/flushed).
- ex_pc  in  32  execute-stage PC.
- ex_inst  in  32  execute-stage instruction.
- br_eq  in  1  rs1 == rs2 from the comparator.
- br_lt  in  1  rs1 < rs2 from the comparator (signedness already applied per funct3).
- ex_pred_taken  in  1  prediction made for this instruction at fetch, piped down.
- ex_is_branch  out  1  ex_valid and the instruction is a valid conditional branch.
- ex_taken  out  1  resolved outcome; 0 when ex_is_branch=0.
- mispredict  out  1  ex_is_branch and (ex_taken != ex_pred_taken).
- stats_clr  in  1  synchronous clear of both statistics counters.
- br_count  out  CNT_W  number of resolved branches.
- mispred_count  out  CNT_W  number of mispredicted branches.

Behaviour:
- Decode:
  - A valid branch is opcode OPC_BRANCH with funct3 in {BEQ, BNE, BLT, BGE, BLTU, BGEU}.
  - funct3 010/011 under OPC_BRANCH is not a branch: no update, no count, ex_taken=0, mispredict=0.
- Resolution (combinational):
  - BEQ: taken = br_eq.
  - BNE: taken = !br_eq.
  - BLT/BLTU: taken = br_lt.
  - BGE/BGEU: taken = !br_lt.
- Indexing: idx = pc[IDX_W+1:2] for both read and update. pc[1:0] is ignored. Aliasing is permitted.
- Prediction: if_pred_taken = table[idx(if_pc)][CTR_W-1]. Pure combinational read, no latency.
- Update, on the clock edge when ex_is_branch=1:
  - Taken: counter increments, saturating at 2^CTR_W-1.
  - Not taken: counter decrements, saturating at 0.
  - Otherwise the table is unchanged.
- Same-cycle read/write to the same index: if_pred_taken reflects the pre-update value. No bypass; the new value is visible the next cycle.
- Statistics:
  - On each ex_is_branch cycle, br_count += 1.
  - If mispredict is also asserted, mispred_count += 1.
  - Both counters wrap modulo 2^CNT_W.
  - stats_clr has priority: a clear in the same cycle as a branch yields 0, not 1.
- ex_valid=0 masks everything: ex_is_branch, ex_taken and mispredict are 0, and there is no update or count, regardless of ex_inst.
- Reset (rst_n low, asynchronous):
  - All counters go to INIT_CTR; br_count and mispred_count go to 0.
  - Reset asserted mid-update wins. Deassertion is synchronised externally.
- Combinational outputs after reset follow their inputs; at reset with defaults, if_pred_taken=0 for every PC.

Test Plan:
- Reset then sweep if_pc 0x0..0xFC: if_pred_taken=0 everywhere; br_count=mispred_count=0.
- BEQ (funct3 000) at ex_pc=0x40 with br_eq=1, ex_pred_taken=0 in 3 consecutive cycles: ex_taken=1, mispredict=1 on each.
  - Counter at idx 16 goes 1→2→3→3 (saturates); if_pc=0x40 predicts 1 from the cycle after the first update.
  - br_count=3, mispred_count=3.
- BGEU at 0x80 with br_lt=1, counter at 0: ex_taken=0, counter stays 0 (saturates low). BNE with br_eq=0: ex_taken=1.
- Aliasing: PCs 0x0 and 0x100 (ENTRIES=64) share idx 0. Training 0x0 taken twice gives if_pc=0x100 prediction 1.
- Masking: ex_valid=0 with a taken BEQ, and OPC_BRANCH with funct3=010 while valid: no counter or table change, mispredict=0.
- stats_clr asserted in the same cycle as a mispredicted branch: both counts 0 next cycle. rst_n pulsed low mid-sequence: table returns to INIT_CTR immediately, without waiting for a clock edge.
